// File: rtl/mem_pkg.sv
// Shared field layout for the EXE/MEM (133-bit) and MEM/WB (71-bit) buses,
// plus the memory-stage FSM state type.
package mem_pkg;

   localparam int unsigned IN_W   = 133;
   localparam int unsigned WB_W   = 71;
   localparam int unsigned DATA_W = 32;

   // EXE/MEM bus fields
   localparam int unsigned IN_ZERO      = 0;
   localparam int unsigned IN_REGWR     = 1;
   localparam int unsigned IN_M2R       = 2;
   localparam int unsigned IN_MEMWR     = 3;
   localparam int unsigned IN_BEQ       = 4;
   localparam int unsigned IN_JUMP      = 5;
   localparam int unsigned IN_WREG_LSB  = 6;
   localparam int unsigned WREG_W       = 5;
   localparam int unsigned IN_ALU_LSB   = 11;
   localparam int unsigned IN_WDATA_LSB = 43;
   localparam int unsigned IN_PCB_LSB   = 75;
   localparam int unsigned IN_PCJ_LSB   = 107;
   localparam int unsigned PCJ_W        = 26;

   // MEM/WB bus fields
   localparam int unsigned WB_REGWR     = 0;
   localparam int unsigned WB_M2R       = 1;
   localparam int unsigned WB_WREG_LSB  = 2;
   localparam int unsigned WB_ALU_LSB   = 7;
   localparam int unsigned WB_RDATA_LSB = 39;

   typedef enum logic {IDLE, WAIT} state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: asynchronous clear, load-enabled capture.
module mem_wb_reg
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            clr,
   input  logic            load,
   input  logic [WB_W-1:0] d,
   output logic [WB_W-1:0] q
);

   logic [WB_W-1:0] wb_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)       wb_q <= '0;
      else if (load) wb_q <= d;
   end

   assign q = wb_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives a req/ack data-memory port, stalls while an access is
// outstanding, resolves redirects. Optional alignment check: MEM_ALIGN_CHECK_EN.
module mem_stage
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic [IN_W-1:0]   in_bus,
   input  logic [3:0]        pc4_hi,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic [WB_W-1:0]   wb_bus
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              mem_misalign
`endif
);

   state_e          state_q, state_d;
   logic [IN_W-1:0] hold_q, hold_d;
   logic [IN_W-1:0] act;
   logic            mem_op, is_store, misal, complete, bubble, wb_load;
   logic [WB_W-1:0] wb_d;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;

      act      = (state_q == WAIT) ? hold_q : in_bus;
      mem_op   = act[IN_M2R] | act[IN_MEMWR];
      is_store = act[IN_MEMWR];
`ifdef MEM_ALIGN_CHECK_EN
      misal    = mem_op & (act[IN_ALU_LSB +: 2] != 2'b00);
`else
      misal    = 1'b0;
`endif

      // clr gates the request combinationally so an abandoned access drops at once
      dmem_req   = ~clr & mem_op & ~misal;
      dmem_we    = dmem_req & is_store;
      dmem_addr  = act[IN_ALU_LSB +: DATA_W];
      dmem_wdata = act[IN_WDATA_LSB +: DATA_W];
      stall      = dmem_req & ~dmem_ack;

      complete = ~clr & (dmem_req ? dmem_ack : 1'b1);
      bubble   = (state_q == IDLE) & (in_bus == '0);
      wb_load  = complete | bubble;

      redirect    = 1'b0;
      redirect_pc = '0;
      if (complete) begin
         if (act[IN_JUMP]) begin
            redirect    = 1'b1;
            redirect_pc = {pc4_hi, act[IN_PCJ_LSB +: PCJ_W], 2'b00};
         end else if (act[IN_BEQ] & act[IN_ZERO]) begin
            redirect    = 1'b1;
            redirect_pc = act[IN_PCB_LSB +: DATA_W];
         end
      end

      wb_d = '0;
      wb_d[WB_REGWR]                 = act[IN_REGWR] & ~misal;
      wb_d[WB_M2R]                   = act[IN_M2R];
      wb_d[WB_WREG_LSB +: WREG_W]    = act[IN_WREG_LSB +: WREG_W];
      wb_d[WB_ALU_LSB +: DATA_W]     = act[IN_ALU_LSB +: DATA_W];
      wb_d[WB_RDATA_LSB +: DATA_W]   = (dmem_req & ~is_store) ? dmem_rdata : '0;

`ifdef MEM_ALIGN_CHECK_EN
      mem_misalign = ~clr & misal;
`endif

      case (state_q)
         IDLE: if (stall) begin
            state_d = WAIT;
            hold_d  = in_bus;
         end
         WAIT: if (dmem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   mem_wb_reg u_wb (
      .clk  (clk),
      .clr  (clr),
      .load (wb_load),
      .d    (wb_d),
      .q    (wb_bus)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage plus multi-cycle corner sequences.
module tb_mem_stage;

   logic         clk, clr;
   logic [132:0] in_bus;
   logic [3:0]   pc4_hi;
   logic         dmem_req, dmem_we, dmem_ack, stall, redirect;
   logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata, redirect_pc;
   logic [70:0]  wb_bus;
`ifdef MEM_ALIGN_CHECK_EN
   logic         mem_misalign;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   mem_stage dut (
      .clk         (clk),
      .clr         (clr),
      .in_bus      (in_bus),
      .pc4_hi      (pc4_hi),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .wb_bus      (wb_bus)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .mem_misalign(mem_misalign)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [132:0] mk_bus(input logic z, rw, m2r, mw, beq, j,
                                           input logic [4:0] wr, input logic [31:0] alu, wd, pcb,
                                           input logic [25:0] pcj);
      return {pcj, pcb, wd, alu, wr, j, beq, mw, m2r, rw, z};
   endfunction

   function automatic logic [70:0] mk_wb(input logic rw, m2r, input logic [4:0] wr,
                                         input logic [31:0] alu, rd);
      return {rd, alu, wr, m2r, rw};
   endfunction

   task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string        name;
      logic [132:0] bus;
      logic [3:0]   hi;
      logic         ack;
      logic [31:0]  rd;
      logic         req, we, st, redir;
      logic [31:0]  rpc, addr, wdata;
      logic [70:0]  wb;
   } vec_t;

   vec_t vec [10];
   logic ld_done;
   int unsigned stall_cnt;

   initial begin
      vec[0] = '{"add",     mk_bus(0,1,0,0,0,0,5'd5,32'h10,0,0,0), 4'h0, 0, 32'h0,
                 0,0,0,0, 32'h0, 32'h10, 32'h0, mk_wb(1,0,5'd5,32'h10,0)};
      vec[1] = '{"store",   mk_bus(0,0,0,1,0,0,5'd0,32'h200,32'h1234,0,0), 4'h0, 1, 32'hFFFF_FFFF,
                 1,1,0,0, 32'h0, 32'h200, 32'h1234, mk_wb(0,0,5'd0,32'h200,0)};
      vec[2] = '{"load0",   mk_bus(0,1,1,0,0,0,5'd7,32'h300,0,0,0), 4'h0, 1, 32'hCAFE_F00D,
                 1,0,0,0, 32'h0, 32'h300, 32'h0, mk_wb(1,1,5'd7,32'h300,32'hCAFE_F00D)};
      vec[3] = '{"beq",     mk_bus(1,0,0,0,1,0,5'd0,0,0,32'h40,0), 4'h0, 0, 32'h0,
                 0,0,0,1, 32'h40, 32'h0, 32'h0, mk_wb(0,0,5'd0,0,0)};
      vec[4] = '{"jump",    mk_bus(0,0,0,0,0,1,5'd0,0,0,0,26'h10), 4'h1, 0, 32'h0,
                 0,0,0,1, 32'h1000_0040, 32'h0, 32'h0, mk_wb(0,0,5'd0,0,0)};
      vec[5] = '{"beq_nz",  mk_bus(0,0,0,0,1,0,5'd0,0,0,32'h40,0), 4'h0, 0, 32'h0,
                 0,0,0,0, 32'h0, 32'h0, 32'h0, mk_wb(0,0,5'd0,0,0)};
      vec[6] = '{"jmp_pri", mk_bus(1,0,0,0,1,1,5'd0,0,0,32'h80,26'h3), 4'hA, 0, 32'h0,
                 0,0,0,1, 32'hA000_000C, 32'h0, 32'h0, mk_wb(0,0,5'd0,0,0)};
      vec[7] = '{"st_ld",   mk_bus(0,1,1,1,0,0,5'd2,32'h24,32'hAB,0,0), 4'h0, 1, 32'h5555,
                 1,1,0,0, 32'h0, 32'h24, 32'hAB, mk_wb(1,1,5'd2,32'h24,0)};
      vec[8] = '{"bubble",  133'd0, 4'h0, 1, 32'hFFFF,
                 0,0,0,0, 32'h0, 32'h0, 32'h0, 71'd0};
      vec[9] = '{"ld_br",   mk_bus(1,1,1,0,1,0,5'd6,32'h50,0,32'h88,0), 4'h0, 1, 32'h0BAD_F00D,
                 1,0,0,1, 32'h88, 32'h50, 32'h0, mk_wb(1,1,5'd6,32'h50,32'h0BAD_F00D)};

      // reset
      clr = 1'b1; in_bus = '0; pc4_hi = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      #12;
      chk("rst_wb", wb_bus, 71'd0);
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_redir", redirect, 0);
      @(posedge clk); #1 clr = 1'b0;

      // single-cycle table
      for (int i = 0; i < 10; i++) begin
         in_bus = vec[i].bus; pc4_hi = vec[i].hi;
         dmem_ack = vec[i].ack; dmem_rdata = vec[i].rd;
         @(negedge clk);
         chk({vec[i].name, "_req"},   dmem_req,   vec[i].req);
         chk({vec[i].name, "_we"},    dmem_we,    vec[i].we);
         chk({vec[i].name, "_stall"}, stall,      vec[i].st);
         chk({vec[i].name, "_redir"}, redirect,   vec[i].redir);
         if (vec[i].redir) chk({vec[i].name, "_rpc"}, redirect_pc, vec[i].rpc);
         chk({vec[i].name, "_addr"},  dmem_addr,  vec[i].addr);
         chk({vec[i].name, "_wdata"}, dmem_wdata, vec[i].wdata);
         @(posedge clk); #1;
         chk({vec[i].name, "_wb"},    wb_bus,     vec[i].wb);
      end

      // load from 0x100, ack three cycles after the request; in_bus changes during WAIT
      in_bus = mk_bus(0,1,1,0,0,0,5'd9,32'h100,0,0,0);
      dmem_ack = 1'b0; dmem_rdata = '0; pc4_hi = '0;
      ld_done = 1'b0; stall_cnt = 0;
      for (int c = 0; c < 12 && !ld_done; c++) begin
         if (c == 1) in_bus = mk_bus(0,0,0,1,0,0,5'd0,32'h998,32'h77,0,0);
         if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
         @(negedge clk);
         if (c == 2) begin
            chk("wait_addr", dmem_addr, 32'h100);
            chk("wait_we", dmem_we, 0);
            chk("wait_req", dmem_req, 1);
         end
         if (stall) stall_cnt++;
         if (dmem_req && dmem_ack) ld_done = 1'b1;
         if (c == 3) chk("ack_redir", redirect, 0);
         @(posedge clk); #1;
      end
      chk("ld3_done", ld_done, 1);
      chk("ld3_stall_cycles", stall_cnt, 3);
      chk("ld3_wb", wb_bus, mk_wb(1,1,5'd9,32'h100,32'hDEAD_BEEF));

      // clr while waiting on a load to 0x400
      in_bus = mk_bus(0,1,1,0,0,0,5'd3,32'h400,0,0,0);
      dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      chk("clrw_stall", stall, 1);
      @(posedge clk); #1;
      chk("clrw_wb_held", wb_bus, mk_wb(1,1,5'd9,32'h100,32'hDEAD_BEEF));
      #2 clr = 1'b1;
      #1;
      chk("clrw_req", dmem_req, 0);
      chk("clrw_wb", wb_bus, 71'd0);
      chk("clrw_stall0", stall, 0);
      @(posedge clk); #1;
      clr = 1'b0; in_bus = '0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_ack_req", dmem_req, 0);
      chk("late_ack_stall", stall, 0);
      @(posedge clk); #1;
      chk("late_ack_wb", wb_bus, 71'd0);
      dmem_ack = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
      in_bus = mk_bus(0,1,1,0,0,0,5'd4,32'h102,0,0,0);
      @(negedge clk);
      chk("mis_req", dmem_req, 0);
      chk("mis_flag", mem_misalign, 1);
      chk("mis_stall", stall, 0);
      @(posedge clk); #1;
      chk("mis_wb", wb_bus, mk_wb(0,1,5'd4,32'h102,0));
      in_bus = '0;
      @(negedge clk);
      chk("mis_pulse_end", mem_misalign, 0);
      @(posedge clk); #1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage consumer of the 133-bit EXE/MEM pipeline bus. It unpacks the bus and drives a variable-latency data-memory port with a req/ack handshake. It stalls the pipeline while an access is outstanding, resolves branch/jump redirects, and registers the 71-bit MEM/WB bus for write-back. It sits between the EXE/MEM pipeline register and the write-back stage.

## Interface
- No parameters; all widths are fixed by the bus layout.
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- in_bus  in  133  EXE/MEM bus:
  - [0] zero, [1] RegWrite, [2] MemToReg, [3] MemWrite, [4] BranchEq, [5] Jump
  - [10:6] writeReg, [42:11] alu_out, [74:43] writeData, [106:75] pcBranch, [132:107] pcJump
- pc4_hi  in  4  upper PC+4 bits, used for the jump target
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  alu_out
- dmem_wdata  out  32  writeData
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  32  load data
- stall  out  1  freeze upstream stages (PC, IF/ID, ID/EX, EXE/MEM)
- redirect  out  1  taken branch or jump; upstream flushes
- redirect_pc  out  32  redirect target
- wb_bus  out  71  MEM/WB bus:
  - [0] RegWrite, [1] MemToReg, [6:2] writeReg, [38:7] alu_out, [70:39] read data
- mem_misalign  out  1  misaligned access pulse; exists only with MEM_ALIGN_CHECK_EN

## Operation
- Memory op: MemToReg=1 is a load, MemWrite=1 is a store. Both set is treated as a store, and RegWrite still passes through.
- An all-zero in_bus is a bubble: no request, no redirect, and wb_bus loads zero.
- FSM states: IDLE, WAIT.
- IDLE, non-memory op: wb_bus is registered from in_bus at the next edge; read-data field is 0.
- IDLE, memory op:
  - dmem_req=1 combinationally from in_bus.
  - If dmem_ack=1 in the same cycle, the access completes and the FSM stays in IDLE.
  - Otherwise the whole in_bus is captured into a hold register and the FSM moves to WAIT.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are driven from the hold register, not from in_bus; in_bus is ignored.
  - On dmem_ack, wb_bus is registered from the hold register plus dmem_rdata, and the FSM returns to IDLE.
- stall = dmem_req & ~dmem_ack. It is combinational and covers both IDLE and WAIT.
- Completion cycle: the cycle an instruction leaves the stage (non-memory op in IDLE, or the ack cycle).
- Redirect, evaluated only in the completion cycle, using the active op (hold register in WAIT, otherwise in_bus):
  - Jump → redirect=1, redirect_pc={pc4_hi, pcJump, 2'b00}.
  - Else BranchEq & zero → redirect=1, redirect_pc=pcBranch.
  - Jump takes priority when both are set.
  - redirect=0 whenever stall=1.
- Stores: the read-data field of wb_bus is 0.
- dmem_ack while dmem_req=0 is ignored.

## Timing
- Reset values: FSM=IDLE, hold register=0, wb_bus=0. All combinational outputs evaluate to 0 for a zero hold register and a zero in_bus.
- Non-memory op: wb_bus is valid 1 edge after the op appears on in_bus.
- Memory op with N-cycle ack latency (N≥0 cycles after the request is raised):
  - stall is high for N cycles.
  - wb_bus updates at the edge ending the ack cycle.
- clr during WAIT:
  - dmem_req drops immediately (asynchronously); the pending access is abandoned.
  - A late ack is ignored.
- The upstream next op must be presented in the cycle after the completion cycle; the FSM consumes it from IDLE.

## Configuration
- MEM_ALIGN_CHECK_EN, when defined:
  - A memory op with alu_out[1:0]≠0 issues no request.
  - mem_misalign pulses for 1 cycle (combinational, in the completion cycle).
  - wb_bus captures that op with RegWrite forced to 0.
- MEM_ALIGN_CHECK_EN, when undefined:
  - The mem_misalign port does not exist.
  - No alignment check is made; address low bits pass through unchanged.

## Structure
- Shared package mem_pkg holds:
  - bit offsets and widths for every in_bus and wb_bus field
  - the bus widths 133 and 71
  - the FSM state enum {IDLE, WAIT}
- Sub-module mem_wb_reg: the 71-bit MEM/WB register with asynchronous clr and a load-enable. mem_stage drives load=completion cycle | bubble.

## Test plan
- Add with in_bus RegWrite=1, writeReg=5, alu_out=0x10 → next edge wb_bus: RegWrite=1, writeReg=5, alu_out=0x10, read data=0; stall never high.
- Load from 0x100 with ack after 3 cycles, rdata=0xDEADBEEF:
  - stall high 3 cycles; dmem_addr holds 0x100 even when in_bus is changed during WAIT.
  - wb_bus read data=0xDEADBEEF, MemToReg=1.
- Store of 0x1234 to 0x200 with same-cycle ack → dmem_we=1, dmem_wdata=0x1234, stall=0, no WAIT entry.
- Redirects:
  - BranchEq=1, zero=1, pcBranch=0x40 → redirect=1, redirect_pc=0x40.
  - Jump=1 with pcJump=0x000_0010, pc4_hi=0x1 → redirect_pc=0x1000_0040.
  - zero=0 → redirect=0.
- clr asserted in WAIT → dmem_req falls immediately, wb_bus=0, FSM IDLE; a subsequent ack causes no wb_bus change.
- With MEM_ALIGN_CHECK_EN: load at 0x102 → no dmem_req, mem_misalign=1 for 1 cycle, wb_bus RegWrite=0.
